// File: rtl/dram_timed.sv
// Latency-accurate word-addressed memory with valid/ready request and response,
// byte-enable writes, optional zero-fill after reset and bad-address reporting.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_CLEAR | zero-filling the array, one word per cycle
// S_IDLE  | waiting for a request (req_ready high)
// S_WAIT  | access accepted, counting down the configured latency
// S_RESP  | response held on resp_* until the consumer takes it
module dram_timed #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_WORDS      = 1024,
   parameter int LATENCY        = 4,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_be,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic                    resp_err,
   output logic                    busy
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int OFS      = $clog2(BE_WIDTH);
   localparam int IDX_W    = ADDR_WIDTH - OFS;
   localparam int MW_W     = $clog2(MEM_WORDS);
   localparam int CLR_W    = MW_W + 1;
   localparam int LAT_W    = $clog2(LATENCY) + 1;

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_IDLE  = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t state, state_n;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   logic [CLR_W-1:0]      clear_cnt;
   logic [LAT_W-1:0]      lat_cnt;

   logic                  lq_write;
   logic [ADDR_WIDTH-1:0] lq_addr;
   logic [DATA_WIDTH-1:0] lq_wdata;
   logic [BE_WIDTH-1:0]   lq_be;

   logic                  accept;
   logic                  commit;
   logic                  clear_we;

   logic [IDX_W-1:0]      acc_idx;
   logic [MW_W-1:0]       widx;
   logic                  acc_err;
   logic [DATA_WIDTH-1:0] wr_word;

   // Range check is done at 64 bits so a wide index is never truncated before the compare.
   always_comb begin
      acc_idx = lq_addr[ADDR_WIDTH-1:OFS];
      widx    = acc_idx[MW_W-1:0];
      acc_err = (lq_addr[OFS-1:0] != '0) || (64'(acc_idx) >= 64'(MEM_WORDS));
   end

   always_comb begin
      wr_word = mem[widx];
      for (int b = 0; b < BE_WIDTH; b++) begin
         if (lq_be[b]) begin
            wr_word[8*b +: 8] = lq_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      accept   = 1'b0;
      commit   = 1'b0;
      clear_we = 1'b0;
      case (state)
         S_CLEAR: begin
            clear_we = 1'b1;
            if (clear_cnt == CLR_W'(MEM_WORDS - 1)) begin
               state_n = S_IDLE;
            end
         end
         S_IDLE: begin
            if (req_valid && req_ready) begin
               accept  = 1'b1;
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (lat_cnt == '0) begin
               commit  = 1'b1;
               state_n = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_valid && resp_ready) begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they take their
   // reset values while rst is low and never depend combinationally on req_valid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clear_cnt  <= '0;
         lat_cnt    <= '0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         busy       <= 1'b1;
      end else begin
         req_ready  <= (state_n == S_IDLE);
         resp_valid <= (state_n == S_RESP);
         busy       <= (state_n != S_IDLE);
         if (clear_we) begin
            clear_cnt <= clear_cnt + 1'b1;
         end
         if (accept) begin
            lat_cnt  <= LAT_W'(LATENCY - 1);
            lq_write <= req_write;
            lq_addr  <= req_addr;
            lq_wdata <= req_wdata;
            lq_be    <= req_be;
         end else if (state == S_WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
         end
         if (commit) begin
            resp_err   <= acc_err;
            resp_rdata <= (acc_err || lq_write) ? '0 : mem[widx];
         end
      end
   end

   // Array has no reset; writes are suppressed on any edge where rst is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (clear_we) begin
            mem[clear_cnt[MW_W-1:0]] <= '0;
         end else if (commit && lq_write && !acc_err) begin
            mem[widx] <= wr_word;
         end
      end
   end

endmodule
